// File: rtl/ula_pkg.sv
// Shared select/mode constants and the per-bit X/Y term helpers for the 74181-style ALU.
// Optional signed-overflow output on ula_8bits is enabled by defining ULA_OVERFLOW_EN.
package ula_pkg;

    localparam logic [3:0] S_A       = 4'h0;
    localparam logic [3:0] S_OR      = 4'h1;
    localparam logic [3:0] S_OR_NB   = 4'h2;
    localparam logic [3:0] S_ONES    = 4'h3;
    localparam logic [3:0] S_A_P_ANB = 4'h4;
    localparam logic [3:0] S_OR_ANB  = 4'h5;
    localparam logic [3:0] S_SUB_M1  = 4'h6;
    localparam logic [3:0] S_ANB_M1  = 4'h7;
    localparam logic [3:0] S_A_P_AB  = 4'h8;
    localparam logic [3:0] S_ADD     = 4'h9;
    localparam logic [3:0] S_ONB_AB  = 4'hA;
    localparam logic [3:0] S_AB_M1   = 4'hB;
    localparam logic [3:0] S_DBL     = 4'hC;
    localparam logic [3:0] S_OR_P_A  = 4'hD;
    localparam logic [3:0] S_ONB_P_A = 4'hE;
    localparam logic [3:0] S_DEC     = 4'hF;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // X and Y are the two half-sum operands; logic mode is ~(X^Y), arithmetic mode is X+Y+c_in.
    function automatic logic [3:0] x_term(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s);
        return a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    endfunction

    function automatic logic [3:0] y_term(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s);
        return (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    endfunction

endpackage

// File: rtl/ula_4bits.sv
// Combinational 4-bit 74181-style slice with active-high data and carry.
import ula_pkg::*;

module ula_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    always_comb begin
        x   = x_term(a, b, s);
        y   = y_term(a, b, s);
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
        if (m == MODE_LOGIC) begin
            f     = ~(x ^ y);
            c_out = 1'b0;
        end else begin
            f     = sum[3:0];
            c_out = sum[4];
        end
    end

endmodule

// File: rtl/ula_8bits.sv
// 8-bit 74181-style ALU: two ripple-carry slices with registered f, c_out and a_eq_b.
// Defining ULA_OVERFLOW_EN adds the registered signed-overflow output ovf.
import ula_pkg::*;

module ula_8bits (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       c_out,
`ifdef ULA_OVERFLOW_EN
    output logic       ovf,
`endif
    output logic       a_eq_b
);

    logic [3:0] f_lo;
    logic [3:0] f_hi;
    logic       c_mid;
    logic       c_hi;
    logic [7:0] f_next;

    ula_4bits u_slice0 (
        .a     (a[3:0]),
        .b     (b[3:0]),
        .s     (s),
        .m     (m),
        .c_in  (c_in),
        .f     (f_lo),
        .c_out (c_mid)
    );

    ula_4bits u_slice1 (
        .a     (a[7:4]),
        .b     (b[7:4]),
        .s     (s),
        .m     (m),
        .c_in  (c_mid),
        .f     (f_hi),
        .c_out (c_hi)
    );

    assign f_next = {f_hi, f_lo};

`ifdef ULA_OVERFLOW_EN
    logic [3:0] x_hi;
    logic [3:0] y_hi;
    logic       ovf_next;

    // Sign bits of the two addends are recomputed here since the slice only exports f/c_out.
    always_comb begin
        x_hi     = x_term(a[7:4], b[7:4], s);
        y_hi     = y_term(a[7:4], b[7:4], s);
        ovf_next = (m == MODE_ARITH) && (x_hi[3] == y_hi[3]) && (f_next[7] != x_hi[3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            f      <= '0;
            c_out  <= 1'b0;
            a_eq_b <= 1'b0;
        end else begin
            f      <= f_next;
            c_out  <= c_hi;
            a_eq_b <= (f_next == 8'hFF);
        end
    end

endmodule

// File: tb/tb_ula_8bits.sv
// Self-checking bench for ula_8bits: directed cases plus random stimulus against a table-driven model.
module tb_ula_8bits;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [7:0] f;
    logic       c_out;
    logic       a_eq_b;
`ifdef ULA_OVERFLOW_EN
    logic       ovf;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    ula_8bits dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (f),
        .c_out  (c_out),
`ifdef ULA_OVERFLOW_EN
        .ovf    (ovf),
`endif
        .a_eq_b (a_eq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference straight from the function tables; "-1" terms add 8'hFF.
    task automatic ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic [3:0] rs,
                             input logic rm, input logic rc,
                             output logic [7:0] ef, output logic ec, output logic ev);
        logic [7:0] p;
        logic [7:0] q;
        logic [8:0] sum;
        ec = 1'b0;
        ev = 1'b0;
        if (rm) begin
            case (rs)
                4'h0: ef = ~ra;
                4'h1: ef = ~(ra | rb);
                4'h2: ef = ~ra & rb;
                4'h3: ef = 8'h00;
                4'h4: ef = ~(ra & rb);
                4'h5: ef = ~rb;
                4'h6: ef = ra ^ rb;
                4'h7: ef = ra & ~rb;
                4'h8: ef = ~ra | rb;
                4'h9: ef = ~(ra ^ rb);
                4'hA: ef = rb;
                4'hB: ef = ra & rb;
                4'hC: ef = 8'hFF;
                4'hD: ef = ra | ~rb;
                4'hE: ef = ra | rb;
                default: ef = ra;
            endcase
        end else begin
            case (rs)
                4'h0: begin p = ra;        q = 8'h00;     end
                4'h1: begin p = ra | rb;   q = 8'h00;     end
                4'h2: begin p = ra | ~rb;  q = 8'h00;     end
                4'h3: begin p = 8'hFF;     q = 8'h00;     end
                4'h4: begin p = ra;        q = ra & ~rb;  end
                4'h5: begin p = ra | rb;   q = ra & ~rb;  end
                4'h6: begin p = ra;        q = ~rb;       end
                4'h7: begin p = ra & ~rb;  q = 8'hFF;     end
                4'h8: begin p = ra;        q = ra & rb;   end
                4'h9: begin p = ra;        q = rb;        end
                4'hA: begin p = ra | ~rb;  q = ra & rb;   end
                4'hB: begin p = ra & rb;   q = 8'hFF;     end
                4'hC: begin p = ra;        q = ra;        end
                4'hD: begin p = ra | rb;   q = ra;        end
                4'hE: begin p = ra | ~rb;  q = ra;        end
                default: begin p = ra;     q = 8'hFF;     end
            endcase
            sum = {1'b0, p} + {1'b0, q} + {8'h00, rc};
            ef  = sum[7:0];
            ec  = sum[8];
            ev  = (p[7] == q[7]) && (ef[7] != p[7]);
        end
    endtask

    task automatic apply(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                         input logic tm, input logic tc);
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; c_in = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                             input logic [3:0] ts, input logic tm, input logic tc);
        logic [7:0] ef;
        logic       ec;
        logic       ev;
        ref_model(ta, tb, ts, tm, tc, ef, ec, ev);
        check({tag, ".f"}, {8'h00, f}, {8'h00, ef});
        check({tag, ".c_out"}, {15'h0, c_out}, {15'h0, ec});
        check({tag, ".a_eq_b"}, {15'h0, a_eq_b}, {15'h0, (ef == 8'hFF)});
`ifdef ULA_OVERFLOW_EN
        check({tag, ".ovf"}, {15'h0, ovf}, {15'h0, ev});
`endif
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rs;
        logic       rm;
        logic       rc;

        rst = 1'b1; a = 8'hFF; b = 8'hFF; s = 4'h9; m = 1'b0; c_in = 1'b0;
        @(posedge clk);
        #1;
        check("rst.f", {8'h00, f}, 16'h0000);
        check("rst.c_out", {15'h0, c_out}, 16'h0000);
        check("rst.a_eq_b", {15'h0, a_eq_b}, 16'h0000);
`ifdef ULA_OVERFLOW_EN
        check("rst.ovf", {15'h0, ovf}, 16'h0000);
`endif
        @(negedge clk);
        rst = 1'b0;

        apply(8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        check("pass_a.f", {8'h00, f}, 16'h0000);
        apply(8'h00, 8'h4A, 4'h0, 1'b0, 1'b1);
        check("inc_a.f", {8'h00, f}, 16'h0001);
        check("inc_a.c_out", {15'h0, c_out}, 16'h0000);
        apply(8'h18, 8'h4A, 4'h1, 1'b0, 1'b1);
        check("or_c.f", {8'h00, f}, 16'h005B);
        apply(8'h38, 8'h4A, 4'h1, 1'b0, 1'b0);
        check("or.f", {8'h00, f}, 16'h007A);
        apply(8'hC8, 8'h64, 4'h9, 1'b0, 1'b0);
        check("add.f", {8'h00, f}, 16'h002C);
        check("add.c_out", {15'h0, c_out}, 16'h0001);
`ifdef ULA_OVERFLOW_EN
        check("add.ovf", {15'h0, ovf}, 16'h0000);
`endif
        apply(8'h5A, 8'h5A, 4'h6, 1'b0, 1'b0);
        check("eq.f", {8'h00, f}, 16'h00FF);
        check("eq.a_eq_b", {15'h0, a_eq_b}, 16'h0001);
        check("eq.c_out", {15'h0, c_out}, 16'h0000);
        apply(8'h5A, 8'h5B, 4'h6, 1'b0, 1'b0);
        check("neq.f", {8'h00, f}, 16'h00FE);
        check("neq.a_eq_b", {15'h0, a_eq_b}, 16'h0000);
        apply(8'h80, 8'h01, 4'h6, 1'b0, 1'b1);
        check("sub.c_out", {15'h0, c_out}, 16'h0001);
        apply(8'h01, 8'h80, 4'h6, 1'b0, 1'b1);
        check("sub_borrow.c_out", {15'h0, c_out}, 16'h0000);
`ifdef ULA_OVERFLOW_EN
        apply(8'h7F, 8'h01, 4'h9, 1'b0, 1'b0);
        check("pos_ovf.ovf", {15'h0, ovf}, 16'h0001);
`endif

        // Logic sweep also confirms f holds its old value until the next rising edge.
        apply(8'hF0, 8'hCC, 4'h6, 1'b1, 1'b1);
        check("xor.f", {8'h00, f}, 16'h003C);
        check("xor.c_out", {15'h0, c_out}, 16'h0000);
        @(negedge clk);
        s = 4'hB;
        #1;
        check("latency.f", {8'h00, f}, 16'h003C);
        @(posedge clk);
        #1;
        check("and.f", {8'h00, f}, 16'h00C0);
        check("and.c_out", {15'h0, c_out}, 16'h0000);
        apply(8'hF0, 8'hCC, 4'hE, 1'b1, 1'b1);
        check("orl.f", {8'h00, f}, 16'h00FC);
        check("orl.c_out", {15'h0, c_out}, 16'h0000);
        apply(8'hF0, 8'hCC, 4'h3, 1'b1, 1'b1);
        check("zero.f", {8'h00, f}, 16'h0000);
        check("zero.c_out", {15'h0, c_out}, 16'h0000);

        apply(8'hFF, 8'h01, 4'h9, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst.f", {8'h00, f}, 16'h0000);
        check("mid_rst.c_out", {15'h0, c_out}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 8'hFF, 8'h01, 4'h9, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 4'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            apply(ra, rb, rs, rm, rc);
            check_all($sformatf("rand%0d_s%0h_m%0d", i, rs, rm), ra, rb, rs, rm, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
